sevseg_scan_latch: RTL and testbench



---
 rtl/sevseg_scan_latch.sv | 113 +++++++++++
 tb/tb_sevseg_scan_latch.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sevseg_scan_latch.sv
// Latched, time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A load strobe captures the value to show; a free-running counter scans digits with a per-slot anode guard.
module sevseg_scan_latch #(
  parameter int          CNT_W     = 19,
  parameter int unsigned GUARD_CYC = 64,
  parameter bit          BLANK_LZ  = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] din,
  input  logic [3:0]  dp_in,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [15:0] shown
);

  typedef enum logic {
    PH_GUARD  = 1'b0,
    PH_ACTIVE = 1'b1
  } phase_t;

  logic [CNT_W-1:0] r_cnt;
  logic [15:0]      r_shown;
  logic [3:0]       r_dp_hold;
  logic [6:0]       r_seg;
  logic             r_dp;
  logic [3:0]       r_an;

  logic [1:0]       w_idx;
  logic [CNT_W-3:0] w_low;
  phase_t           w_phase;
  logic [3:0]       w_nib;
  logic [3:0]       w_zero_from;
  logic             w_dig_blank;

  function automatic logic [6:0] hex_seg(input logic [3:0] v);
    case (v)
      4'h0: hex_seg = 7'h40;
      4'h1: hex_seg = 7'h79;
      4'h2: hex_seg = 7'h24;
      4'h3: hex_seg = 7'h30;
      4'h4: hex_seg = 7'h19;
      4'h5: hex_seg = 7'h12;
      4'h6: hex_seg = 7'h02;
      4'h7: hex_seg = 7'h78;
      4'h8: hex_seg = 7'h00;
      4'h9: hex_seg = 7'h10;
      4'hA: hex_seg = 7'h08;
      4'hB: hex_seg = 7'h03;
      4'hC: hex_seg = 7'h46;
      4'hD: hex_seg = 7'h21;
      4'hE: hex_seg = 7'h06;
      default: hex_seg = 7'h0E;
    endcase
  endfunction

  assign w_idx   = r_cnt[CNT_W-1 -: 2];
  assign w_low   = r_cnt[CNT_W-3:0];
  assign w_phase = (32'(w_low) < GUARD_CYC) ? PH_GUARD : PH_ACTIVE;

  always_comb begin
    w_nib = r_shown[3:0];
    case (w_idx)
      2'd0: w_nib = r_shown[3:0];
      2'd1: w_nib = r_shown[7:4];
      2'd2: w_nib = r_shown[11:8];
      default: w_nib = r_shown[15:12];
    endcase
  end

  // w_zero_from[i]: nibbles i..3 are all zero; digit 0 is never a leading zero.
  always_comb begin
    w_zero_from[3] = (r_shown[15:12] == 4'h0);
    w_zero_from[2] = w_zero_from[3] && (r_shown[11:8] == 4'h0);
    w_zero_from[1] = w_zero_from[2] && (r_shown[7:4] == 4'h0);
    w_zero_from[0] = 1'b0;
  end

  assign w_dig_blank = BLANK_LZ && w_zero_from[w_idx];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt     <= '0;
      r_shown   <= '0;
      r_dp_hold <= '0;
      r_seg     <= 7'h7F;
      r_dp      <= 1'b1;
      r_an      <= 4'hF;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      if (load) begin
        r_shown   <= din;
        r_dp_hold <= dp_in;
      end
      r_seg <= w_dig_blank ? 7'h7F : hex_seg(w_nib);
      r_dp  <= ~r_dp_hold[w_idx];
      // Segments already carry the new digit during the guard; only anodes stay dark.
      if (blank || (w_phase == PH_GUARD) || w_dig_blank)
        r_an <= 4'hF;
      else
        r_an <= ~(4'b0001 << w_idx);
    end
  end

  assign seg   = r_seg;
  assign dp    = r_dp;
  assign an    = r_an;
  assign shown = r_shown;

endmodule

// File: tb/tb_sevseg_scan_latch.sv
// Directed bench for sevseg_scan_latch with a 4-cycle slot and a 1-cycle guard.
// One instance without and one with leading-zero blanking share the same stimulus.
module tb_sevseg_scan_latch;

  logic        clk = 1'b0;
  logic        reset, load, blank;
  logic [15:0] din;
  logic [3:0]  dp_in;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1;
  logic [3:0]  an0, an1;
  logic [15:0] shown0, shown1;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  sevseg_scan_latch #(.CNT_W(4), .GUARD_CYC(1), .BLANK_LZ(1'b0)) u_dut0 (
    .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in), .blank(blank),
    .seg(seg0), .dp(dp0), .an(an0), .shown(shown0)
  );

  sevseg_scan_latch #(.CNT_W(4), .GUARD_CYC(1), .BLANK_LZ(1'b1)) u_dut1 (
    .clk(clk), .reset(reset), .load(load), .din(din), .dp_in(dp_in), .blank(blank),
    .seg(seg1), .dp(dp1), .an(an1), .shown(shown1)
  );

  // Anode pattern for a counter value s (before the edge), blanking ignored.
  function automatic logic [3:0] exp_an(input int s);
    logic [3:0] one;
    int idx;
    one = 4'b0001;
    idx = (s >> 2) & 3;
    if ((s & 3) == 0) return 4'hF;
    return ~(one << idx);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at post-reset cycle 0 (cnt = 0, outputs at reset values).
  task automatic do_reset();
    reset = 1'b1; load = 1'b0; blank = 1'b0; din = '0; dp_in = '0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (an0 !== 4'hF) begin n_err++; $display("FAIL reset_an got %h exp F", an0); end
    n_chk++; if (seg0 !== 7'h7F) begin n_err++; $display("FAIL reset_seg got %h exp 7F", seg0); end
    n_chk++; if (dp0 !== 1'b1) begin n_err++; $display("FAIL reset_dp got %b exp 1", dp0); end
    n_chk++; if (shown0 !== 16'h0) begin n_err++; $display("FAIL reset_shown got %h exp 0", shown0); end
    n_chk++; if (an1 !== 4'hF || seg1 !== 7'h7F) begin
      n_err++; $display("FAIL reset_lz got an=%h seg=%h exp an=F seg=7F", an1, seg1);
    end
  endtask

  task automatic test_idle();
    logic [3:0] e1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      n_chk++; if (an0 !== exp_an(c-1)) begin n_err++; $display("FAIL idle_an c=%0d got %h exp %h", c, an0, exp_an(c-1)); end
      n_chk++; if (seg0 !== 7'h40) begin n_err++; $display("FAIL idle_seg c=%0d got %h exp 40", c, seg0); end
      n_chk++; if (dp0 !== 1'b1) begin n_err++; $display("FAIL idle_dp c=%0d got %b exp 1", c, dp0); end
      e1 = (((c-1) >> 2) == 0) ? exp_an(c-1) : 4'hF;
      n_chk++; if (an1 !== e1) begin n_err++; $display("FAIL idle_lz_an c=%0d got %h exp %h", c, an1, e1); end
    end
  endtask

  task automatic test_load_pattern();
    logic [6:0] tbl [4];
    int idx;
    tbl = '{7'h0E, 7'h08, 7'h24, 7'h79};
    do_reset();
    load = 1'b1; din = 16'h12AF; dp_in = 4'b0100;
    tick();
    load = 1'b0; din = '0; dp_in = '0;
    n_chk++; if (shown0 !== 16'h12AF) begin n_err++; $display("FAIL load_shown got %h exp 12AF", shown0); end
    n_chk++; if (seg0 !== 7'h40) begin n_err++; $display("FAIL load_latency got %h exp 40", seg0); end
    for (int c = 2; c <= 17; c++) begin
      tick();
      idx = ((c-1) >> 2) & 3;
      n_chk++; if (an0 !== exp_an(c-1)) begin n_err++; $display("FAIL load_an c=%0d got %h exp %h", c, an0, exp_an(c-1)); end
      n_chk++; if (seg0 !== tbl[idx]) begin n_err++; $display("FAIL load_seg c=%0d got %h exp %h", c, seg0, tbl[idx]); end
      n_chk++; if (dp0 !== (idx != 2)) begin n_err++; $display("FAIL load_dp c=%0d got %b exp %b", c, dp0, idx != 2); end
    end
  endtask

  // segs: expected glyphs {d3,d2,d1,d0}; blanked: digits expected dark on the LZ instance.
  task automatic test_lz(input logic [15:0] val, input logic [27:0] segs, input logic [3:0] blanked);
    int idx;
    logic [6:0] es;
    logic [3:0] ea;
    do_reset();
    load = 1'b1; din = val;
    tick();
    load = 1'b0; din = '0;
    for (int c = 2; c <= 17; c++) begin
      tick();
      idx = ((c-1) >> 2) & 3;
      es = blanked[idx] ? 7'h7F : segs[idx*7 +: 7];
      ea = blanked[idx] ? 4'hF : exp_an(c-1);
      n_chk++; if (seg1 !== es) begin n_err++; $display("FAIL lz_seg val=%h c=%0d got %h exp %h", val, c, seg1, es); end
      n_chk++; if (an1 !== ea) begin n_err++; $display("FAIL lz_an val=%h c=%0d got %h exp %h", val, c, an1, ea); end
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    load = 1'b1; din = 16'h1111;
    tick();
    din = 16'h2222;
    tick();
    load = 1'b0; din = '0;
    n_chk++; if (shown0 !== 16'h2222) begin n_err++; $display("FAIL b2b_shown got %h exp 2222", shown0); end
    n_chk++; if (seg0 !== 7'h79 || an0 !== 4'hE) begin
      n_err++; $display("FAIL b2b_first got seg=%h an=%h exp seg=79 an=E", seg0, an0);
    end
    for (int c = 3; c <= 18; c++) begin
      tick();
      n_chk++; if (seg0 !== 7'h24) begin n_err++; $display("FAIL b2b_seg c=%0d got %h exp 24", c, seg0); end
    end
  endtask

  task automatic test_blank();
    logic [3:0] ea;
    do_reset();
    for (int c = 1; c <= 20; c++) begin
      blank = (c >= 7 && c <= 11);
      tick();
      ea = (c >= 7 && c <= 11) ? 4'hF : exp_an(c-1);
      n_chk++; if (an0 !== ea) begin n_err++; $display("FAIL blank_an c=%0d got %h exp %h", c, an0, ea); end
    end
    blank = 1'b0;
  endtask

  task automatic test_reset_mid_scan();
    do_reset();
    for (int c = 1; c <= 10; c++) tick();
    n_chk++; if (an0 !== 4'hB) begin n_err++; $display("FAIL mid_pre_an got %h exp B", an0); end
    reset = 1'b1; load = 1'b1; din = 16'hFFFF;
    tick();
    reset = 1'b0; load = 1'b0; din = '0;
    n_chk++; if (shown0 !== 16'h0) begin n_err++; $display("FAIL mid_shown got %h exp 0", shown0); end
    n_chk++; if (an0 !== 4'hF || seg0 !== 7'h7F || dp0 !== 1'b1) begin
      n_err++; $display("FAIL mid_out got an=%h seg=%h dp=%b exp F 7F 1", an0, seg0, dp0);
    end
    tick();
    n_chk++; if (an0 !== 4'hF || seg0 !== 7'h40) begin
      n_err++; $display("FAIL mid_guard got an=%h seg=%h exp F 40", an0, seg0);
    end
    tick();
    n_chk++; if (an0 !== 4'hE || shown0 !== 16'h0) begin
      n_err++; $display("FAIL mid_digit0 got an=%h shown=%h exp E 0", an0, shown0);
    end
  endtask

  initial begin
    reset = 1'b0; load = 1'b0; blank = 1'b0; din = '0; dp_in = '0;
    tick();
    test_reset();
    test_idle();
    test_load_pattern();
    test_lz(16'h0007, {7'h7F, 7'h7F, 7'h7F, 7'h78}, 4'b1110);
    test_lz(16'h0000, {7'h7F, 7'h7F, 7'h7F, 7'h40}, 4'b1110);
    test_lz(16'h0100, {7'h7F, 7'h79, 7'h40, 7'h40}, 4'b1000);
    test_back_to_back();
    test_blank();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
